// File: rtl/fifo_reader_if.sv
// Bundle of FIFO-side, downstream-side and status signals for fifo_reader.
// The master modport is the reader controller; the slave modport is the FIFO/sink environment.
interface fifo_reader_if #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0] buf_out;
    logic                  buf_empty;
    logic                  almost_empty;
    logic                  enable;
    logic                  out_ready;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  pop_count;
    logic                  low_water;

    modport master (
        input  buf_out, buf_empty, almost_empty, enable, out_ready,
        output rd_en, out_data, out_valid, busy, pop_count, low_water
    );

    modport slave (
        output buf_out, buf_empty, almost_empty, enable, out_ready,
        input  rd_en, out_data, out_valid, busy, pop_count, low_water
    );
endinterface

// File: rtl/fifo_reader.sv
// Reads a synchronous FIFO (one-cycle read latency) into a 2-entry skid buffer
// and presents words downstream on a valid/ready handshake.
module fifo_reader #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic           clk,
    input  logic           rst,
    fifo_reader_if.master  bus_if
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                state_q;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [CNT_WIDTH-1:0]  pop_count_q;
    logic                  low_water_q;

    logic                  out_valid;
    logic                  xfer;
    logic [1:0]            committed;
    logic                  rd_en;

    assign out_valid = (occ_q != 2'd0);
    assign xfer      = out_valid & bus_if.out_ready;

    // Slots already spoken for once this cycle's transfer leaves; never exceeds 2.
    assign committed = occ_q + {1'b0, inflight_q} - {1'b0, xfer};
    assign rd_en     = bus_if.enable & ~bus_if.buf_empty & (state_q == ACTIVE)
                       & (committed < 2'd2);

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        case ({inflight_q, xfer})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = bus_if.buf_out;
                else               buf1_d = bus_if.buf_out;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = bus_if.buf_out;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = bus_if.buf_out;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            occ_q       <= 2'd0;
            inflight_q  <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            pop_count_q <= '0;
            low_water_q <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            inflight_q  <= rd_en;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            low_water_q <= bus_if.almost_empty;
            if (xfer) pop_count_q <= pop_count_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (bus_if.enable && !bus_if.buf_empty) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (!bus_if.enable)
                        state_q <= DRAIN;
                    else if (bus_if.buf_empty && occ_q == 2'd0 && !inflight_q)
                        state_q <= IDLE;
                end
                DRAIN: begin
                    // Finishing the drain wins over a same-cycle re-enable; IDLE restarts next cycle.
                    if (occ_q == 2'd0 && !inflight_q) state_q <= IDLE;
                    else if (bus_if.enable)           state_q <= ACTIVE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.rd_en     = rd_en;
    assign bus_if.out_data  = buf0_q;
    assign bus_if.out_valid = out_valid;
    assign bus_if.busy      = (state_q != IDLE);
    assign bus_if.pop_count = pop_count_q;
    assign bus_if.low_water = low_water_q;
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-based FIFO model feeds the DUT, a scoreboard
// of pushed words is checked by an independent negedge monitor.
module tb_fifo_reader;
    localparam int DW = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int reads = 0;
    int deliv = 0;
    int model_cnt = 0;
    bit rd_log[$];
    bit ov_log[$];

    task automatic chk_eq(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        bus.buf_empty = 1'b0;
    endtask

    // One clock of the FIFO model: a read seen during the cycle returns its word after the edge.
    task automatic tick();
        bit rd_s;
        @(negedge clk);
        rd_s = bus.rd_en;
        rd_log.push_back(rd_s);
        ov_log.push_back(bus.out_valid);
        @(posedge clk);
        #1;
        if (rd_s) begin
            chk_eq("read_nonempty_fifo", int'(fifo_q.size() > 0), 1);
            if (fifo_q.size() > 0) begin
                bus.buf_out = fifo_q.pop_front();
                reads++;
            end
        end
        bus.buf_empty    = (fifo_q.size() == 0);
        bus.almost_empty = 1'($urandom_range(0, 1));
    endtask

    function automatic int count_ones(input bit q[$]);
        int n = 0;
        foreach (q[i]) if (q[i]) n++;
        return n;
    endfunction

    function automatic int first_one(input bit q[$]);
        foreach (q[i]) if (q[i]) return i;
        return -100;
    endfunction

    function automatic int last_one(input bit q[$]);
        for (int i = q.size() - 1; i >= 0; i--) if (q[i]) return i;
        return -200;
    endfunction

    // Monitor / scoreboard
    logic [DW-1:0] prev_data;
    bit prev_stall = 1'b0;
    bit ae_prev    = 1'b0;
    bit lw_ok      = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            model_cnt  = 0;
            prev_stall = 1'b0;
            lw_ok      = 1'b0;
        end else begin
            chk_eq("pop_count", int'(bus.pop_count), model_cnt);
            if (lw_ok) chk_eq("low_water", int'(bus.low_water), int'(ae_prev));
            if (prev_stall) begin
                chk_eq("hold_valid", int'(bus.out_valid), 1);
                chk_eq("hold_data", int'(bus.out_data), int'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %0d, expected no word", bus.out_data);
                end else begin
                    chk_eq("out_data", int'(bus.out_data), int'(exp_q.pop_front()));
                end
                model_cnt = (model_cnt + 1) % (1 << CW);
                deliv++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            ae_prev    = bus.almost_empty;
            lw_ok      = 1'b1;
        end
    end

    initial begin
        logic [DW-1:0] words[16];
        int f;
        int nrd;
        int base;

        rst              = 1'b1;
        bus.enable       = 1'b0;
        bus.out_ready    = 1'b0;
        bus.buf_empty    = 1'b1;
        bus.almost_empty = 1'b0;
        bus.buf_out      = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_out_valid", int'(bus.out_valid), 0);
        chk_eq("rst_busy", int'(bus.busy), 0);
        chk_eq("rst_rd_en", int'(bus.rd_en), 0);
        chk_eq("rst_pop_count", int'(bus.pop_count), 0);
        chk_eq("rst_low_water", int'(bus.low_water), 0);
        chk_eq("rst_out_data", int'(bus.out_data), 0);
        rst = 1'b0;

        // Three words, free-flowing downstream
        rd_log.delete(); ov_log.delete();
        push(4'd1); push(4'd2); push(4'd3);
        bus.enable = 1'b1; bus.out_ready = 1'b1;
        repeat (10) tick();
        f = first_one(rd_log);
        chk_eq("s1_rd_count", count_ones(rd_log), 3);
        chk_eq("s1_rd_consecutive", last_one(rd_log) - f, 2);
        chk_eq("s1_latency", first_one(ov_log) - f, 2);
        chk_eq("s1_valid_count", count_ones(ov_log), 3);
        chk_eq("s1_valid_consecutive", last_one(ov_log) - first_one(ov_log), 2);
        chk_eq("s1_pop_count", int'(bus.pop_count), 3);
        chk_eq("s1_busy", int'(bus.busy), 0);

        // Empty FIFO never read, then a single word
        rd_log.delete();
        repeat (5) tick();
        chk_eq("s2_no_read", count_ones(rd_log), 0);
        chk_eq("s2_out_valid", int'(bus.out_valid), 0);
        chk_eq("s2_idle", int'(bus.busy), 0);
        push(4'd10);
        repeat (8) tick();
        chk_eq("s2_pop_count", int'(bus.pop_count), 4);

        // Back-pressure: only two words may be pulled while blocked
        words = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                  4'd5, 4'd6, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
        bus.out_ready = 1'b0;
        foreach (words[i]) push(words[i]);
        rd_log.delete();
        repeat (10) tick();
        chk_eq("s3_blocked_reads", count_ones(rd_log), 2);
        chk_eq("s3_out_valid", int'(bus.out_valid), 1);
        chk_eq("s3_head_word", int'(bus.out_data), int'(words[0]));
        bus.out_ready = 1'b1;
        repeat (30) tick();
        chk_eq("s3_pop_count", int'(bus.pop_count), 20);
        chk_eq("s3_all_delivered", exp_q.size(), 0);

        // Drop enable after the third read
        for (int i = 0; i < 8; i++) push(4'($urandom_range(0, 15)));
        rd_log.delete();
        nrd = 0;
        for (int i = 0; i < 20 && nrd < 3; i++) begin
            tick();
            if (rd_log[rd_log.size() - 1]) nrd++;
        end
        chk_eq("s4_third_read_seen", nrd, 3);
        bus.enable = 1'b0;
        tick();
        chk_eq("s4_draining_busy", int'(bus.busy), 1);
        repeat (10) tick();
        chk_eq("s4_reads", count_ones(rd_log), 3);
        chk_eq("s4_idle", int'(bus.busy), 0);
        chk_eq("s4_pop_count", int'(bus.pop_count), 23);
        chk_eq("s4_fifo_left", fifo_q.size(), 5);

        // Asynchronous reset with a full skid buffer
        bus.out_ready = 1'b0;
        bus.enable    = 1'b1;
        repeat (6) tick();
        chk_eq("s5_pre_valid", int'(bus.out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("s5_rst_out_valid", int'(bus.out_valid), 0);
        chk_eq("s5_rst_pop_count", int'(bus.pop_count), 0);
        chk_eq("s5_rst_rd_en", int'(bus.rd_en), 0);
        chk_eq("s5_rst_busy", int'(bus.busy), 0);
        repeat (reads - deliv) void'(exp_q.pop_front());
        deliv = reads;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // pop_count wrap: exactly 256 transfers, then one more
        base = deliv;
        bus.out_ready = 1'b1;
        for (int i = fifo_q.size(); i < 256; i++) push(4'($urandom_range(0, 15)));
        repeat (300) tick();
        chk_eq("s6_xfers", deliv - base, 256);
        chk_eq("s6_wrap", int'(bus.pop_count), 0);
        push(4'($urandom_range(0, 15)));
        repeat (8) tick();
        chk_eq("s6_after_wrap", int'(bus.pop_count), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 24)
                push(4'($urandom_range(0, 15)));
            bus.enable    = ($urandom_range(0, 7) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !bus.busy) break;
            tick();
        end
        chk_eq("final_scoreboard_empty", exp_q.size(), 0);
        chk_eq("final_fifo_empty", fifo_q.size(), 0);
        chk_eq("final_idle", int'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
